// File: rtl/key_schedule_pkg.sv
// Shared AES definitions for the key schedule slice.
// Provides the AES-128 size constants, the key-schedule FSM state type, the round constant
// lookup and the AES S-box lookup used by sub_bytes.
package key_schedule_pkg;

  localparam int unsigned AES_ROUNDS = 10;
  localparam int unsigned AES_KEY_W  = 128;

  typedef enum logic {StIdle, StEmit} state_e;

  // Rcon for rounds 1..10, round 1 in the top byte.
  localparam logic [8*AES_ROUNDS-1:0] RCON_TABLE = 80'h01020408102040801b36;

  // AES S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for rounds 1..10; any other round yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    int r;
    r = int'(round);
    if (r < 1 || r > int'(AES_ROUNDS)) begin
      return 8'h00;
    end
    return RCON_TABLE[8*(int'(AES_ROUNDS) - r) +: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Handshake bundle between a key source, the key schedule and the downstream round stage.
//   key_v_i / key_i / key_ready_o              : cipher key intake
//   round_key_v_o / round_key_o / round_idx_o  : round key stream, index 0..10
//   round_key_last_o                           : marks round 10
//   round_key_ready_i                          : downstream consumes the current round key
// Modport slave is the key schedule side, master is the driving side.
interface key_schedule_if;
  import key_schedule_pkg::*;

  logic                 key_v_i;
  logic [AES_KEY_W-1:0] key_i;
  logic                 key_ready_o;
  logic                 round_key_v_o;
  logic [AES_KEY_W-1:0] round_key_o;
  logic [3:0]           round_idx_o;
  logic                 round_key_last_o;
  logic                 round_key_ready_i;

  modport slave (
    input  key_v_i, key_i, round_key_ready_i,
    output key_ready_o, round_key_v_o, round_key_o, round_idx_o, round_key_last_o
  );

  modport master (
    output key_v_i, key_i, round_key_ready_i,
    input  key_ready_o, round_key_v_o, round_key_o, round_idx_o, round_key_last_o
  );

endinterface

// File: rtl/key_schedule_sub_bytes.sv
// sub_bytes: applies the AES S-box independently to each byte of a NumBytes-wide word.
//   data_i : input bytes
//   data_o : substituted bytes, same byte positions
module sub_bytes
  import key_schedule_pkg::*;
#(
  parameter int unsigned NumBytes = 16
) (
  input  logic [8*NumBytes-1:0] data_i,
  output logic [8*NumBytes-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(NumBytes); i++) begin
      data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/key_schedule.sv
// key_schedule: AES-128 on-the-fly key expansion.
// Accepts one cipher key, then streams round keys 0..10 one per downstream handshake.
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   ks        : key intake and round key stream (key_schedule_if.slave)
module key_schedule
  import key_schedule_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_n_i,
  key_schedule_if.slave  ks
);

  localparam logic [3:0] LastIdx = 4'(AES_ROUNDS);

  state_e               state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [3:0]           idx_q, idx_d;

  logic [31:0]          w3_rot, w3_sub, temp;
  logic [31:0]          w0_n, w1_n, w2_n, w3_n;
  logic [AES_KEY_W-1:0] next_key;

  // Next round key, derived only from the registered key and index.
  assign w3_rot = {key_q[23:0], key_q[31:24]};

  sub_bytes #(
    .NumBytes(4)
  ) u_sub_word (
    .data_i(w3_rot),
    .data_o(w3_sub)
  );

  assign temp     = w3_sub ^ {rcon(idx_q + 4'd1), 24'h000000};
  assign w0_n     = key_q[127:96] ^ temp;
  assign w1_n     = key_q[95:64]  ^ w0_n;
  assign w2_n     = key_q[63:32]  ^ w1_n;
  assign w3_n     = key_q[31:0]   ^ w2_n;
  assign next_key = {w0_n, w1_n, w2_n, w3_n};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (ks.key_v_i) begin
          key_d   = ks.key_i;
          idx_d   = 4'd0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (ks.round_key_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; no input-to-output paths.
  always_comb begin
    ks.key_ready_o      = (state_q == StIdle);
    ks.round_key_v_o    = (state_q == StEmit);
    ks.round_key_o      = key_q;
    ks.round_idx_o      = idx_q;
    ks.round_key_last_o = (state_q == StEmit) && (idx_q == LastIdx);
  end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: FIPS-197 style expansion model plus directed vectors.
module tb_key_schedule;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  key_schedule_if ks_if ();

  key_schedule u_dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .ks       (ks_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KeyA1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1Idx1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1Idx10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroIdx1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KeyB    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KeyC    = 128'hffeeddccbbaa99887766554433221100;

  logic [7:0] sbox_m [256];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} >> (8 - n);
    return d[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-wise key expansion w[0..43], grouped into the 11 round keys.
  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0]        w [44];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [10:0][127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) res[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return res;
  endfunction

  // Transaction-level model: one key in, eleven round keys out, then idle again.
  logic               m_emit = 1'b0;
  int                 m_idx  = 0;
  logic [10:0][127:0] m_sched;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_emit = 1'b0;
      m_idx  = 0;
    end else if (!m_emit) begin
      if (ks_if.key_v_i) begin
        m_sched = expand(ks_if.key_i);
        m_idx   = 0;
        m_emit  = 1'b1;
      end
    end else if (ks_if.round_key_ready_i) begin
      if (m_idx == 10) m_emit = 1'b0;
      else m_idx++;
    end
  end

  always @(negedge clk) begin
    check("cmp key_ready", 128'(ks_if.key_ready_o), 128'(!m_emit));
    check("cmp round_key_v", 128'(ks_if.round_key_v_o), 128'(m_emit));
    check("cmp round_key_last", 128'(ks_if.round_key_last_o), 128'(m_emit && m_idx == 10));
    if (m_emit) begin
      check("cmp round_idx", 128'(ks_if.round_idx_o), 128'(m_idx));
      check("cmp round_key", ks_if.round_key_o, m_sched[m_idx]);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " key_ready"}, 128'(ks_if.key_ready_o), 128'(1));
    check({tag, " round_key_v"}, 128'(ks_if.round_key_v_o), 128'(0));
    check({tag, " round_key"}, ks_if.round_key_o, 128'(0));
    check({tag, " round_idx"}, 128'(ks_if.round_idx_o), 128'(0));
    check({tag, " round_key_last"}, 128'(ks_if.round_key_last_o), 128'(0));
  endtask

  task automatic start_key(input logic [127:0] k);
    @(negedge clk);
    ks_if.key_i   = k;
    ks_if.key_v_i = 1'b1;
  endtask

  // Returns at the negedge where round n is presented; bounded.
  task automatic wait_round(input int n);
    logic found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (ks_if.round_key_v_o && int'(ks_if.round_idx_o) == n) found = 1'b1;
    end
    check($sformatf("wait round %0d timeout", n), 128'(found), 128'(1));
  endtask

  logic [10:0][127:0] sched_tmp;
  logic [127:0]       held;

  initial begin
    ks_if.key_v_i           = 1'b0;
    ks_if.key_i             = '0;
    ks_if.round_key_ready_i = 1'b1;
    build_sbox();

    // Pin the model against the published vectors.
    sched_tmp = expand(KeyA1);
    check("model A1 idx1", sched_tmp[1], A1Idx1);
    check("model A1 idx10", sched_tmp[10], A1Idx10);
    sched_tmp = expand(128'h0);
    check("model zero idx1", sched_tmp[1], ZeroIdx1);

    #1 reset_n = 1'b0;
    #1 check_reset_values("reset");
    #20 reset_n = 1'b1;

    // FIPS-197 A.1 with ready held high.
    start_key(KeyA1);
    wait_round(0);
    ks_if.key_v_i = 1'b0;
    check("A1 idx0", ks_if.round_key_o, KeyA1);
    wait_round(1);
    check("A1 idx1", ks_if.round_key_o, A1Idx1);
    wait_round(10);
    check("A1 idx10", ks_if.round_key_o, A1Idx10);
    check("A1 last", 128'(ks_if.round_key_last_o), 128'(1));
    @(negedge clk);
    check("A1 key_ready after", 128'(ks_if.key_ready_o), 128'(1));

    // All-zero key.
    start_key(128'h0);
    wait_round(1);
    ks_if.key_v_i = 1'b0;
    check("zero idx1", ks_if.round_key_o, ZeroIdx1);
    wait_round(10);
    @(negedge clk);

    // Backpressure: five stalled cycles at round 3.
    start_key(KeyA1);
    wait_round(0);
    ks_if.key_v_i = 1'b0;
    wait_round(3);
    ks_if.round_key_ready_i = 1'b0;
    held = ks_if.round_key_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall idx", 128'(ks_if.round_idx_o), 128'(3));
      check("stall key", ks_if.round_key_o, held);
      check("stall valid", 128'(ks_if.round_key_v_o), 128'(1));
    end
    ks_if.round_key_ready_i = 1'b1;
    @(negedge clk);
    sched_tmp = expand(KeyA1);
    check("after stall idx", 128'(ks_if.round_idx_o), 128'(4));
    check("after stall key", ks_if.round_key_o, sched_tmp[4]);
    wait_round(10);
    @(negedge clk);

    // Reset in the middle of a sequence, then a fresh key.
    start_key(KeyA1);
    wait_round(0);
    ks_if.key_v_i = 1'b0;
    wait_round(6);
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid reset");
    @(negedge clk);
    check_reset_values("mid reset held");
    #2 reset_n = 1'b1;
    start_key(KeyB);
    wait_round(0);
    ks_if.key_v_i = 1'b0;
    check("restart idx0", ks_if.round_key_o, KeyB);
    wait_round(10);
    @(negedge clk);

    // Busy rejection then back-to-back acceptance with key_v held high.
    start_key(KeyA1);
    wait_round(0);
    ks_if.key_i = KeyC;
    wait_round(10);
    check("busy idx10", ks_if.round_key_o, A1Idx10);
    @(negedge clk);
    check("b2b ready", 128'(ks_if.key_ready_o), 128'(1));
    check("b2b gap valid", 128'(ks_if.round_key_v_o), 128'(0));
    @(negedge clk);
    check("b2b valid", 128'(ks_if.round_key_v_o), 128'(1));
    check("b2b idx0", 128'(ks_if.round_idx_o), 128'(0));
    check("b2b key", ks_if.round_key_o, KeyC);
    ks_if.key_v_i = 1'b0;
    wait_round(10);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL expose clk_i  input  1  single clock; every register updates on its rising edge.
REQ-002 SHALL expose reset_n_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose key_v_i  input  1  cipher key valid.
REQ-004 SHALL expose key_i  input  128  AES-128 cipher key; byte 0 is bits [127:120]; word w0 is bits [127:96].
REQ-005 SHALL expose key_ready_o  output  1  block can accept a cipher key.
REQ-006 SHALL expose round_key_v_o  output  1  round key valid.
REQ-007 SHALL expose round_key_o  output  128  current round key, same byte order as key_i.
REQ-008 SHALL expose round_idx_o  output  4  round number of round_key_o, 0..10.
REQ-009 SHALL expose round_key_last_o  output  1  high when round_key_v_o=1 and round_idx_o=10.
REQ-010 SHALL expose round_key_ready_i  input  1  downstream round stage consumes the current round key.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-012 SHALL drive key_ready_o=1 exactly when the state is IDLE (decoded from state, no combinational path from inputs).
REQ-013 SHALL accept a key on a rising edge where key_v_i & key_ready_o, then load key_i into the key register, set the index to 0 and enter EMIT.
REQ-014 SHALL make round key 0 (equal to key_i) valid on the cycle after acceptance, giving a latency of 1 cycle.
REQ-015 SHALL drive round_key_v_o=1 exactly when the state is EMIT.
REQ-016 SHALL treat a round handshake as round_key_v_o & round_key_ready_i.
REQ-017 SHALL, on a round handshake with index < 10, replace the key register with the next expanded key, increment the index and remain in EMIT.
REQ-018 SHALL compute the next key as follows: temp = SubWord(RotWord(w3)) ^ {Rcon[idx+1], 24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-019 SHALL define RotWord(w) = {w[23:0], w[31:24]}, and SubWord SHALL apply the AES S-box to each byte.
REQ-020 SHALL use Rcon for rounds 1..10 = 01,02,04,08,10,20,40,80,1B,36.
REQ-021 SHALL hold round_key_o, round_idx_o and round_key_v_o stable while round_key_v_o=1 and round_key_ready_i=0 (backpressure), for any number of stall cycles.
REQ-022 SHALL return to IDLE on the round handshake at index 10; key_ready_o SHALL rise on the next cycle.
REQ-023 SHALL ignore key_v_i while in EMIT, leaving key_i unsampled and the sequence undisturbed.
REQ-024 SHALL need at least 12 cycles per key (1 accept + 11 round beats); there is no overlap between successive keys.
REQ-025 SHALL make the key and index registers purely sequential, with the next-key logic combinational from the key register and index.

Reset
REQ-026 SHALL, on assertion of reset_n_i at any time, including mid-sequence, immediately force state=IDLE, index=0 and key register=0, giving key_ready_o=1, round_key_v_o=0, round_key_o=0, round_idx_o=0 and round_key_last_o=0.
REQ-027 SHALL, after reset deassertion, accept a key in the first cycle key_v_i=1, and no partial sequence from before the reset SHALL resume.

Structure
REQ-028 SHALL take the Rcon table, the state enum, and the AES_ROUNDS=10 / AES_KEY_W=128 constants from the shared AES package.
REQ-029 SHALL implement SubWord as one instance of the existing sub_bytes module parameterised to 4 bytes; no other sub-modules.

Verification
REQ-030 SHALL cover the FIPS-197 A.1 vector: key_i=2b7e151628aed2a6abf7158809cf4f3c with round_key_ready_i=1 -> idx0=2b7e1516..., idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6 with round_key_last_o=1, then key_ready_o=1.
REQ-031 SHALL cover an all-zero key: key_i=0 -> idx1=62636363626363636263636362636363.
REQ-032 SHALL cover backpressure: ready low for 5 cycles at idx 3 -> outputs unchanged for those 5 cycles, then idx 4 on the cycle after ready rises.
REQ-033 SHALL cover reset mid-operation: reset_n_i pulsed low at idx 6 -> outputs go to reset values without waiting for a clock edge; a new key then restarts at idx 0.
REQ-034 SHALL cover busy rejection: key_v_i held high with a different key during EMIT -> key_ready_o=0 and the sequence matches the original key to idx 10.
REQ-035 SHALL cover back-to-back keys: a second key presented with key_v_i high continuously -> accepted exactly 1 cycle after the idx10 handshake.
